// File: rtl/fib_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fib_pkg
// Brief   : Shared state encoding, default frame length and width helper.
// Revision: 1.0
// ============================================================================
package fib_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COUNT  = 2'd1,
        ST_REPORT = 2'd2
    } state_e;

    localparam int DEFAULT_FRAME_LEN = 16;

    // Bits needed to hold any value in 0..frame_len inclusive.
    function automatic int cnt_width(input int frame_len);
        return $clog2(frame_len + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fib_run_tracker.sv
`default_nettype none
// ============================================================================
// Module  : fib_run_tracker
// Brief   : Current and longest run of consecutive hits among enabled samples.
// Revision: 1.0
// ============================================================================
module fib_run_tracker #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             hit,
    output logic [CNT_W-1:0] cur_run,
    output logic [CNT_W-1:0] max_run
);

    logic [CNT_W-1:0] cur_run_q, cur_run_d;
    logic [CNT_W-1:0] max_run_q, max_run_d;
    logic [CNT_W-1:0] run_inc;

    assign run_inc = cur_run_q + CNT_W'(1);

    always_comb begin
        cur_run_d = cur_run_q;
        max_run_d = max_run_q;
        if (clr) begin
            cur_run_d = '0;
            max_run_d = '0;
        end else if (en) begin
            if (hit) begin
                cur_run_d = run_inc;
                // Compare against the post-increment run so the current sample counts.
                if (run_inc > max_run_q) begin
                    max_run_d = run_inc;
                end
            end else begin
                cur_run_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_run_q <= '0;
            max_run_q <= '0;
        end else begin
            cur_run_q <= cur_run_d;
            max_run_q <= max_run_d;
        end
    end

    assign cur_run = cur_run_q;
    assign max_run = max_run_q;

endmodule
`default_nettype wire

// File: rtl/fib_frame_tally.sv
`default_nettype none
// ============================================================================
// Module  : fib_frame_tally
// Brief   : Per-frame hit count and longest hit run over detector verdicts.
// Revision: 1.0
// ============================================================================
module fib_frame_tally
    import fib_pkg::*;
#(
    parameter int FRAME_LEN = DEFAULT_FRAME_LEN,
    parameter int CNT_W     = cnt_width(FRAME_LEN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             is_fib,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] max_run,
    output logic             busy
);

    generate
        if ((FRAME_LEN < 1) || ((2 ** CNT_W) <= FRAME_LEN)) begin : g_param_check
            $fatal(1, "fib_frame_tally: need FRAME_LEN >= 1 and 2**CNT_W > FRAME_LEN");
        end
    endgenerate

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0] hit_count_q, hit_count_d;
    logic             clr;
    logic             accept;
    logic [CNT_W-1:0] cur_run;

    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        hit_count_d  = hit_count_q;
        clr          = 1'b0;
        accept       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_COUNT;
                    clr          = 1'b1;
                    sample_cnt_d = '0;
                    hit_count_d  = '0;
                end
            end
            ST_COUNT: begin
                // Gap cycles leave every counter, including the run, untouched.
                if (in_valid) begin
                    accept       = 1'b1;
                    sample_cnt_d = sample_cnt_q + CNT_W'(1);
                    if (is_fib) begin
                        hit_count_d = hit_count_q + CNT_W'(1);
                    end
                    if (sample_cnt_q == LAST_IDX) begin
                        state_d = ST_REPORT;
                    end
                end
            end
            ST_REPORT: begin
                if (res_ready) begin
                    if (start) begin
                        state_d      = ST_COUNT;
                        clr          = 1'b1;
                        sample_cnt_d = '0;
                        hit_count_d  = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            sample_cnt_q <= '0;
            hit_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            hit_count_q  <= hit_count_d;
        end
    end

    fib_run_tracker #(
        .CNT_W (CNT_W)
    ) u_run_tracker (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .en      (accept),
        .hit     (is_fib),
        .cur_run (cur_run),
        .max_run (max_run)
    );

    assign in_ready  = (state_q == ST_COUNT);
    assign res_valid = (state_q == ST_REPORT);
    assign busy      = (state_q != ST_IDLE);
    assign hit_count = hit_count_q;

endmodule
`default_nettype wire

// File: doc/fib_frame_tally.md
Name: fib_frame_tally

Overview:
- Downstream consumer of the 4-bit Fibonacci-number detector.
- Accepts one detector verdict (is_fib) per valid sample over a frame of FRAME_LEN samples.
- Reports the frame's hit count and longest consecutive-hit run through a valid/ready result interface.
- Frames are armed by a start pulse; the block sits between the detector and the statistics/report logic.

Parameters:
- FRAME_LEN, 16, samples per frame (>= 1).
- CNT_W, 5, counter/result width; must satisfy 2**CNT_W > FRAME_LEN.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  arms a new frame; honoured only in IDLE, or in REPORT on the handshake cycle.
- in_valid  in  1  sample present.
- in_ready  out  1  block accepting samples.
- is_fib  in  1  detector verdict for the current sample.
- res_valid  out  1  frame result available.
- res_ready  in  1  result consumer ready.
- hit_count  out  CNT_W  number of accepted samples with is_fib=1 in the frame.
- max_run  out  CNT_W  longest run of consecutive accepted samples with is_fib=1.
- busy  out  1  high in COUNT or REPORT.

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE.
  - All counters cleared: sample_cnt, hit_count, cur_run, max_run.
  - in_ready=0, res_valid=0, busy=0.
  - Outputs are registered or decoded from state only; no combinational in->out paths.
- IDLE:
  - in_ready=0, res_valid=0.
  - start=1 -> clear sample_cnt, hit_count, cur_run, max_run; next state COUNT.
- COUNT:
  - in_ready=1; start is ignored.
  - A sample is accepted on a cycle with in_valid && in_ready.
  - On acceptance: sample_cnt += 1.
    - If is_fib=1: hit_count += 1; cur_run += 1; max_run = max(max_run, cur_run+1), using the post-increment run.
    - Else: cur_run = 0.
  - The cycle with in_valid=0 is a gap: no counter changes, and the run is NOT broken.
  - When the accepted sample is the FRAME_LEN-th (sample_cnt == FRAME_LEN-1 before increment) -> REPORT.
  - Latency: res_valid rises the cycle after the last acceptance, with final hit_count/max_run already stable.
- REPORT:
  - res_valid=1, in_ready=0; in_valid is ignored.
  - hit_count and max_run are held stable until the handshake.
  - res_valid && res_ready with start=0 -> IDLE.
  - res_valid && res_ready with start=1 -> counters cleared, COUNT (back-to-back frames, no idle cycle).
  - start without res_ready: ignored.
- Width rules:
  - Counters never exceed FRAME_LEN, so no wrap or saturation logic is needed.
  - The CNT_W constraint is checked by an elaboration-time assertion.
- hit_count and max_run are visible in all states but are meaningful only while res_valid=1.
- Reset mid-frame or mid-report: immediate return to IDLE with all outputs zero; no partial result is emitted.

Decomposition:
- Shared package fib_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_COUNT=2'd1, ST_REPORT=2'd2;
  - default FRAME_LEN=16;
  - counter-width helper function (ceil log2 of FRAME_LEN+1).
- One natural sub-module, fib_run_tracker:
  - Inputs: clk, rst_n, clr, en, hit.
  - Outputs: cur_run, max_run (CNT_W each).
  - Instantiated once; the top keeps the FSM, sample_cnt and hit_count.

Test Plan:
1. Sweep frame: start, then drive values 0..15 through a detector instance into is_fib, in_valid=1 every cycle -> res_valid 1 cycle after the 16th acceptance; hit_count=7 (0,1,2,3,5,8,13); max_run=4.
2. Gapped input: same as 1 with in_valid low on alternate cycles -> identical result (7, 4); gaps do not break the run; res_valid exactly 1 cycle after the 16th acceptance.
3. Result backpressure: hold res_ready=0 for 5 cycles in REPORT while toggling in_valid/is_fib -> hit_count/max_run stable, in_ready=0, no counter changes; res_ready=1 -> IDLE next cycle.
4. All hits / no hits: 16 samples with is_fib=1 -> hit_count=16, max_run=16 (no wrap at CNT_W=5). 16 samples with is_fib=0 -> both 0.
5. Back-to-back frames: assert start with res_ready on the handshake cycle -> COUNT next cycle, counters zero, second frame (pattern 1,0,1,1,0,... ) reported independently.
6. Reset mid-frame: deassert rst_n after 7 accepted samples -> outputs 0, state IDLE asynchronously. After release, start plus 16 samples -> result reflects only the new frame.
